// File: rtl/data_ram_ctrl.sv
// Single-port data RAM with byte-enable writes, valid/ready requests, a 1- or
// 2-cycle registered read path, and a clear engine that zeroes the array.
module data_ram_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                clr_start,
  output logic                busy
);

  localparam int unsigned      NB      = DATA_W / 8;
  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   clr_cnt;
  logic               clear_we;
  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               rd_v1;
  logic [DATA_W-1:0]  rd_d1;

  assign accept   = req_valid & req_ready;
  assign wr_acc   = accept & req_we;
  assign rd_acc   = accept & ~req_we;
  assign in_range = {1'b0, req_addr} < DEPTH_L;
  assign idx      = req_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
      end
    end
  end

  // A request accepted alongside clr_start is serviced at that same edge,
  // so the sweep can begin on the very next cycle without losing it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST) state_nxt = ST_READY;
      ST_READY: if (clr_start)       state_nxt = ST_CLEAR;
      default:                       state_nxt = state;
    endcase
  end

  // Gating with rst_n keeps req_ready low for the whole reset window.
  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    clear_we  = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        clear_we = rst_n;
      end
      ST_READY: req_ready = rst_n;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else begin
      rd_v1 <= rd_acc;
      if (rd_acc) rd_d1 <= in_range ? mem[idx] : '0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              rd_v2;
    logic [DATA_W-1:0] rd_d2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_d2 <= rd_d1;
      end
    end

    assign rsp_valid = rd_v2;
    assign rsp_rdata = rd_d2;
  end else begin : g_no_out_reg
    assign rsp_valid = rd_v1;
    assign rsp_rdata = rd_d1;
  end

endmodule
